// File: rtl/trap_seq.sv
// ============================================================================
// trap_seq : exception/interrupt/ertn CSR update sequencer at writeback
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

module trap_seq (
    input  logic        clk,
    input  logic        resetn,
    input  logic        wb_valid,
    input  logic [31:0] wb_pc,
    input  logic        wb_ex_req,
    input  logic [5:0]  wb_ecode,
    input  logic [8:0]  wb_esubcode,
    input  logic        wb_badv_valid,
    input  logic [31:0] wb_badv,
    input  logic        wb_ertn_req,
    input  logic        wb_csr_we,
    input  logic [13:0] wb_csr_num,
    input  logic [31:0] wb_csr_wmask,
    input  logic [31:0] wb_csr_wvalue,
    input  logic        int_pending,
    input  logic [31:0] crmd_rvalue,
    input  logic [31:0] prmd_rvalue,
    input  logic [31:0] era_rvalue,
    input  logic [31:0] eentry_rvalue,
    output logic        csr_we,
    output logic [13:0] csr_num,
    output logic [31:0] csr_wmask,
    output logic [31:0] csr_wvalue,
    output logic        busy,
    output logic        wb_ack,
    output logic        wb_kill,
    output logic        flush,
    output logic [31:0] redirect_pc
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        E_PRMD   = 3'd1,
        E_ERA    = 3'd2,
        E_ESTAT  = 3'd3,
        E_BADV   = 3'd4,
        E_CRMD   = 3'd5,
        R_CRMD   = 3'd6,
        REDIRECT = 3'd7
    } state_t;

    state_t state, state_nxt;

    logic        lat_ertn;
    logic [31:0] lat_pc;
    logic [5:0]  lat_ecode;
    logic [8:0]  lat_esubcode;
    logic        lat_badv_valid;
    logic [31:0] lat_badv;
    logic [2:0]  lat_crmd;
    logic [2:0]  lat_prmd;
    logic [31:0] lat_era;
    logic [31:0] lat_eentry;

    logic acc_int, acc_ex, acc_ertn, accept;

    // Only the privilege/IE bits of CRMD and PRMD take part in the sequence.
    logic unused_ok;
    assign unused_ok = ^{crmd_rvalue[31:3], prmd_rvalue[31:3]};

    // Fixed priority: interrupt over exception over ertn.
    assign acc_int  = (state == IDLE) & wb_valid & int_pending;
    assign acc_ex   = (state == IDLE) & wb_valid & wb_ex_req & ~int_pending;
    assign acc_ertn = (state == IDLE) & wb_valid & wb_ertn_req & ~int_pending & ~wb_ex_req;
    assign accept   = acc_int | acc_ex | acc_ertn;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state          <= IDLE;
            lat_ertn       <= 1'b0;
            lat_pc         <= 32'd0;
            lat_ecode      <= 6'd0;
            lat_esubcode   <= 9'd0;
            lat_badv_valid <= 1'b0;
            lat_badv       <= 32'd0;
            lat_crmd       <= 3'd0;
            lat_prmd       <= 3'd0;
            lat_era        <= 32'd0;
            lat_eentry     <= 32'd0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                lat_ertn       <= acc_ertn;
                lat_pc         <= wb_pc;
                lat_ecode      <= acc_int ? 6'd0 : wb_ecode;
                lat_esubcode   <= acc_int ? 9'd0 : wb_esubcode;
                lat_badv_valid <= acc_int ? 1'b0 : wb_badv_valid;
                lat_badv       <= wb_badv;
                lat_crmd       <= crmd_rvalue[2:0];
                lat_prmd       <= prmd_rvalue[2:0];
                lat_era        <= era_rvalue;
                lat_eentry     <= eentry_rvalue;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        busy        = (state != IDLE);
        wb_ack      = 1'b0;
        wb_kill     = 1'b0;
        flush       = 1'b0;
        redirect_pc = 32'd0;
        csr_we      = 1'b0;
        csr_num     = 14'd0;
        csr_wmask   = 32'd0;
        csr_wvalue  = 32'd0;
        case (state)
            IDLE: begin
                if (accept) begin
                    // The instruction's own CSR write is dropped with it.
                    wb_ack    = 1'b1;
                    wb_kill   = acc_int;
                    state_nxt = acc_ertn ? R_CRMD : E_PRMD;
                end else if (wb_csr_we) begin
                    csr_we     = 1'b1;
                    csr_num    = wb_csr_num;
                    csr_wmask  = wb_csr_wmask;
                    csr_wvalue = wb_csr_wvalue;
                end
            end
            E_PRMD: begin
                csr_we     = 1'b1;
                csr_num    = 14'h001;
                csr_wmask  = 32'h0000_0007;
                csr_wvalue = {29'd0, lat_crmd};
                state_nxt  = E_ERA;
            end
            E_ERA: begin
                csr_we     = 1'b1;
                csr_num    = 14'h006;
                csr_wmask  = 32'hFFFF_FFFF;
                csr_wvalue = lat_pc;
                state_nxt  = E_ESTAT;
            end
            E_ESTAT: begin
                csr_we     = 1'b1;
                csr_num    = 14'h005;
                csr_wmask  = 32'h7FFF_0000;
                csr_wvalue = {1'b0, lat_esubcode, lat_ecode, 16'd0};
                state_nxt  = lat_badv_valid ? E_BADV : E_CRMD;
            end
            E_BADV: begin
                csr_we     = 1'b1;
                csr_num    = 14'h007;
                csr_wmask  = 32'hFFFF_FFFF;
                csr_wvalue = lat_badv;
                state_nxt  = E_CRMD;
            end
            E_CRMD: begin
                csr_we     = 1'b1;
                csr_num    = 14'h000;
                csr_wmask  = 32'h0000_0007;
                state_nxt  = REDIRECT;
            end
            R_CRMD: begin
                csr_we     = 1'b1;
                csr_num    = 14'h000;
                csr_wmask  = 32'h0000_0007;
                csr_wvalue = {29'd0, lat_prmd};
                state_nxt  = REDIRECT;
            end
            REDIRECT: begin
                flush       = 1'b1;
                redirect_pc = lat_ertn ? lat_era : lat_eentry;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_trap_seq.sv
// ============================================================================
// tb_trap_seq : self-checking bench for trap_seq with a request-level model
// Rev 1.0     : initial release
// ============================================================================
`default_nettype none

module tb_trap_seq;

    logic        clk = 1'b0;
    logic        resetn;
    logic        wb_valid, wb_ex_req, wb_badv_valid, wb_ertn_req, wb_csr_we, int_pending;
    logic [31:0] wb_pc, wb_badv, wb_csr_wmask, wb_csr_wvalue;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [13:0] wb_csr_num;
    logic [31:0] crmd_rvalue, prmd_rvalue, era_rvalue, eentry_rvalue;
    logic        csr_we, busy, wb_ack, wb_kill, flush;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask, csr_wvalue, redirect_pc;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        we;
        logic [31:0] num;
        logic [31:0] mask;
        logic [31:0] value;
        logic        flush;
        logic [31:0] rpc;
    } ev_t;

    ev_t exp_q[$];

    always #5 clk = ~clk;

    trap_seq dut (
        .clk(clk), .resetn(resetn),
        .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_ex_req(wb_ex_req),
        .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
        .wb_badv_valid(wb_badv_valid), .wb_badv(wb_badv), .wb_ertn_req(wb_ertn_req),
        .wb_csr_we(wb_csr_we), .wb_csr_num(wb_csr_num),
        .wb_csr_wmask(wb_csr_wmask), .wb_csr_wvalue(wb_csr_wvalue),
        .int_pending(int_pending),
        .crmd_rvalue(crmd_rvalue), .prmd_rvalue(prmd_rvalue),
        .era_rvalue(era_rvalue), .eentry_rvalue(eentry_rvalue),
        .csr_we(csr_we), .csr_num(csr_num), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
        .busy(busy), .wb_ack(wb_ack), .wb_kill(wb_kill),
        .flush(flush), .redirect_pc(redirect_pc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_cycle(input string ctx, input ev_t e,
                               input logic busy_e, input logic ack_e, input logic kill_e);
        chk({ctx, ".busy"},  {31'd0, busy},    {31'd0, busy_e});
        chk({ctx, ".ack"},   {31'd0, wb_ack},  {31'd0, ack_e});
        chk({ctx, ".kill"},  {31'd0, wb_kill}, {31'd0, kill_e});
        chk({ctx, ".we"},    {31'd0, csr_we},  {31'd0, e.we});
        chk({ctx, ".num"},   {18'd0, csr_num}, e.num);
        chk({ctx, ".mask"},  csr_wmask,        e.mask);
        chk({ctx, ".value"}, csr_wvalue,       e.value);
        chk({ctx, ".flush"}, {31'd0, flush},   {31'd0, e.flush});
        chk({ctx, ".rpc"},   redirect_pc,      e.rpc);
    endtask

    task automatic clear_in();
        wb_valid = 0; wb_ex_req = 0; wb_ertn_req = 0; int_pending = 0;
        wb_badv_valid = 0; wb_csr_we = 0;
        wb_pc = 0; wb_badv = 0; wb_ecode = 0; wb_esubcode = 0;
        wb_csr_num = 0; wb_csr_wmask = 0; wb_csr_wvalue = 0;
    endtask

    task automatic randomize_in();
        wb_valid      = ($urandom % 8) != 0;
        int_pending   = ($urandom % 4) == 0;
        wb_ex_req     = $urandom % 2;
        wb_ertn_req   = $urandom % 2;
        wb_badv_valid = $urandom % 2;
        wb_csr_we     = $urandom % 2;
        wb_pc         = $urandom; wb_badv = $urandom;
        wb_ecode      = 6'($urandom); wb_esubcode = 9'($urandom);
        wb_csr_num    = 14'($urandom);
        wb_csr_wmask  = $urandom; wb_csr_wvalue = $urandom;
        crmd_rvalue   = $urandom; prmd_rvalue = $urandom;
        era_rvalue    = $urandom; eentry_rvalue = $urandom;
    endtask

    // Inputs for cycle T are already driven; builds the expected transaction and follows it.
    task automatic run_req(input string name, input bit with_noise);
        bit   is_int, is_ex, is_ertn, any;
        ev_t  t_e;
        logic [31:0] ec, es;
        is_int  = wb_valid && int_pending;
        is_ex   = wb_valid && wb_ex_req && !is_int;
        is_ertn = wb_valid && wb_ertn_req && !is_int && !is_ex;
        any     = is_int || is_ex || is_ertn;
        exp_q.delete();
        if (is_int || is_ex) begin
            ec = is_int ? 0 : 32'(wb_ecode);
            es = is_int ? 0 : 32'(wb_esubcode);
            exp_q.push_back(ev_t'{1'b1, 32'h001, 32'h7, crmd_rvalue % 8, 1'b0, 32'd0});
            exp_q.push_back(ev_t'{1'b1, 32'h006, 32'hFFFFFFFF, wb_pc, 1'b0, 32'd0});
            exp_q.push_back(ev_t'{1'b1, 32'h005, 32'h7FFF0000, (es * 64 + ec) * 65536, 1'b0, 32'd0});
            if (is_ex && wb_badv_valid)
                exp_q.push_back(ev_t'{1'b1, 32'h007, 32'hFFFFFFFF, wb_badv, 1'b0, 32'd0});
            exp_q.push_back(ev_t'{1'b1, 32'h000, 32'h7, 32'd0, 1'b0, 32'd0});
            exp_q.push_back(ev_t'{1'b0, 32'd0, 32'd0, 32'd0, 1'b1, eentry_rvalue});
        end else if (is_ertn) begin
            exp_q.push_back(ev_t'{1'b1, 32'h000, 32'h7, prmd_rvalue % 8, 1'b0, 32'd0});
            exp_q.push_back(ev_t'{1'b0, 32'd0, 32'd0, 32'd0, 1'b1, era_rvalue});
        end
        if (!any && wb_csr_we)
            t_e = ev_t'{1'b1, 32'(wb_csr_num), wb_csr_wmask, wb_csr_wvalue, 1'b0, 32'd0};
        else
            t_e = ev_t'{1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0};
        #1 check_cycle({name, ".T"}, t_e, 1'b0, any, is_int);
        foreach (exp_q[i]) begin
            @(negedge clk);
            clear_in();
            if (with_noise) randomize_in();
            #1 check_cycle($sformatf("%s.T+%0d", name, i + 1), exp_q[i], 1'b1, 1'b0, 1'b0);
        end
        if (any) begin
            @(negedge clk);
            clear_in();
            #1 check_cycle({name, ".after"}, ev_t'{1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0},
                           1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        clear_in();
        crmd_rvalue = 0; prmd_rvalue = 0; era_rvalue = 0; eentry_rvalue = 0;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        #1 check_cycle("reset", ev_t'{1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0}, 1'b0, 1'b0, 1'b0);
        resetn = 1'b1;

        // Exception with BADV
        @(negedge clk);
        clear_in();
        wb_valid = 1; wb_ex_req = 1; wb_ecode = 6'h08; wb_esubcode = 0;
        wb_pc = 32'h1C000100; wb_badv_valid = 1; wb_badv = 32'h1234;
        crmd_rvalue = 32'h7; eentry_rvalue = 32'h1C008000;
        run_req("exc", 1'b0);

        // ERTN
        @(negedge clk);
        clear_in();
        wb_valid = 1; wb_ertn_req = 1;
        prmd_rvalue = 32'h5; era_rvalue = 32'h1C000104;
        run_req("ertn", 1'b0);

        // Interrupt beats exception and the instruction's CSR write
        @(negedge clk);
        clear_in();
        wb_valid = 1; int_pending = 1; wb_ex_req = 1; wb_ecode = 6'h3F; wb_esubcode = 9'h1FF;
        wb_badv_valid = 1; wb_badv = 32'hDEAD; wb_csr_we = 1; wb_csr_num = 14'h030;
        wb_csr_wmask = 32'hFF; wb_csr_wvalue = 32'hA5; wb_pc = 32'h1C000200;
        run_req("coll", 1'b1);

        // Pass-through in IDLE
        @(negedge clk);
        clear_in();
        wb_csr_we = 1; wb_csr_num = 14'h030; wb_csr_wmask = 32'hFFFFFFFF; wb_csr_wvalue = 32'hA5;
        run_req("pass", 1'b0);

        // Exception and ertn together act as exception, no BADV; noise while busy
        @(negedge clk);
        clear_in();
        wb_valid = 1; wb_ex_req = 1; wb_ertn_req = 1; wb_ecode = 6'h0B; wb_esubcode = 9'h001;
        wb_pc = 32'h1C000300; eentry_rvalue = 32'h1C00C000;
        run_req("exertn", 1'b1);

        // wb_valid low blocks every request
        @(negedge clk);
        clear_in();
        int_pending = 1; wb_ex_req = 1; wb_ertn_req = 1;
        run_req("novalid", 1'b0);

        // Reset in E_ESTAT aborts without flush
        @(negedge clk);
        clear_in();
        wb_valid = 1; wb_ex_req = 1; wb_ecode = 6'h01; wb_pc = 32'h1C000400;
        #1 chk("mid.ack", {31'd0, wb_ack}, 32'd1);
        repeat (3) begin
            @(negedge clk);
            clear_in();
        end
        #1 chk("mid.estat_num", {18'd0, csr_num}, 32'h005);
        resetn = 1'b0;
        @(negedge clk);
        #1 check_cycle("mid.rst", ev_t'{1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0}, 1'b0, 1'b0, 1'b0);
        resetn = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1 check_cycle("mid.post", ev_t'{1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0},
                           1'b0, 1'b0, 1'b0);
        end

        // Random traffic with noise while busy
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            clear_in();
            randomize_in();
            run_req($sformatf("rnd%0d", n), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
